// File: rtl/cmd_exec_pkg.sv
// Shared types and constants for the knight's-tour command responder.
// Opcode and state encodings, heading presets, and the heading-to-setpoint mapping.
package cmd_exec_pkg;

  typedef enum logic [3:0] {
    OP_CAL      = 4'h0,
    OP_MOVE     = 4'h2,
    OP_MOVE_FAN = 4'h3
  } opcode_e;

  typedef enum logic [2:0] {
    IDLE,
    CAL,
    WAIT_HDNG,
    RAMP_UP,
    RAMP_DOWN
  } state_t;

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  // North maps to an exact zero; every other heading is padded with ones in the fraction.
  function automatic logic [11:0] hdng_setpoint(input logic [7:0] hdg);
    return (hdg == HDG_N) ? 12'h000 : {hdg, 4'hF};
  endfunction

endpackage

// File: rtl/line_cntr.sv
// Counts rising edges of the center IR line sensor while enabled, saturating at 31.
// The edge registered in a cycle is visible on count the following cycle.
module line_cntr (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       cntrIR,
  output logic [4:0] count
);

  logic       cntrIR_q;
  logic [4:0] count_q, count_d;
  logic       rise;

  assign rise = cntrIR & ~cntrIR_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 5'd0;
    end else if (en && rise && (count_q != 5'd31)) begin
      count_d = count_q + 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cntrIR_q <= 1'b0;
      count_q  <= 5'd0;
    end else begin
      cntrIR_q <= cntrIR;
      count_q  <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cmd_exec.sv
// Command responder: accepts calibrate/move commands, ramps forward speed over a counted
// number of line crossings, and reports completion with single-cycle Mealy pulses.
module cmd_exec
  import cmd_exec_pkg::*;
#(
  parameter bit         FAST_SIM  = 1'b1,
  parameter logic [9:0] MAX_FRWRD = 10'h2A0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  output logic        clr_cmd_rdy,
  output logic        send_resp,
  output logic        cal_go,
  input  logic        cal_done,
  input  logic        heading_ok,
  input  logic        cntrIR,
  output logic [11:0] dsrd_hdng,
  output logic [9:0]  frwrd,
  output logic        moving,
  output logic        fanfare_go
);

  localparam logic [9:0] INC = FAST_SIM ? 10'h020 : 10'h003;

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [3:0]  sq_q, sq_d;
  logic [11:0] hdng_q, hdng_d;
  logic [9:0]  frwrd_q, frwrd_d;
  logic        moving_q, moving_d;

  logic [4:0]  line_cnt;
  logic        cnt_clr;
  logic        cnt_en;

  // One extra bit exposes overflow past the ceiling and borrow below zero.
  logic [10:0] up_sum;
  logic [10:0] dn_diff;

  assign up_sum  = {1'b0, frwrd_q} + {1'b0, INC};
  assign dn_diff = {1'b0, frwrd_q} - {INC, 1'b0};
  assign cnt_en  = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);

  line_cntr u_line_cntr (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .cntrIR (cntrIR),
    .count  (line_cnt)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    sq_d        = sq_q;
    hdng_d      = hdng_q;
    frwrd_d     = frwrd_q;
    moving_d    = moving_q;
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
    cal_go      = 1'b0;
    fanfare_go  = 1'b0;
    cnt_clr     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_rdy) begin
          clr_cmd_rdy = 1'b1;
          op_d        = cmd[15:12];
          sq_d        = cmd[3:0];
          case (cmd[15:12])
            OP_CAL: begin
              cal_go  = 1'b1;
              state_d = CAL;
            end
            OP_MOVE, OP_MOVE_FAN: begin
              hdng_d   = hdng_setpoint(cmd[11:4]);
              cnt_clr  = 1'b1;
              moving_d = 1'b1;
              frwrd_d  = 10'd0;
              state_d  = WAIT_HDNG;
            end
            default: send_resp = 1'b1;
          endcase
        end
      end

      CAL: begin
        if (cal_done) begin
          send_resp = 1'b1;
          state_d   = IDLE;
        end
      end

      WAIT_HDNG: begin
        frwrd_d = 10'd0;
        if (heading_ok) begin
          state_d = RAMP_UP;
        end
      end

      RAMP_UP: begin
        frwrd_d = (up_sum > {1'b0, MAX_FRWRD}) ? MAX_FRWRD : up_sum[9:0];
        if (line_cnt >= {sq_q, 1'b0}) begin
          state_d = RAMP_DOWN;
        end
      end

      RAMP_DOWN: begin
        if (frwrd_q == 10'd0) begin
          send_resp  = 1'b1;
          fanfare_go = (op_q == OP_MOVE_FAN);
          moving_d   = 1'b0;
          state_d    = IDLE;
        end else begin
          frwrd_d = dn_diff[10] ? 10'd0 : dn_diff[9:0];
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= 4'd0;
      sq_q     <= 4'd0;
      hdng_q   <= 12'd0;
      frwrd_q  <= 10'd0;
      moving_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sq_q     <= sq_d;
      hdng_q   <= hdng_d;
      frwrd_q  <= frwrd_d;
      moving_q <= moving_d;
    end
  end

  assign dsrd_hdng = hdng_q;
  assign frwrd     = frwrd_q;
  assign moving    = moving_q;

endmodule

// File: tb/tb_cmd_exec.sv
// Directed and randomized bench for cmd_exec; expected speed traces come from closed-form
// ramp arithmetic computed per command from its squares count and sensor schedule.
module tb_cmd_exec;
  import cmd_exec_pkg::*;

  localparam int INC  = 32'h20;
  localparam int MAXF = 32'h2A0;

  logic        clk, rst;
  logic [15:0] cmd;
  logic        cmd_rdy, clr_cmd_rdy, send_resp, cal_go, cal_done;
  logic        heading_ok, cntrIR, moving, fanfare_go;
  logic [11:0] dsrd_hdng;
  logic [9:0]  frwrd;

  int n_chk = 0;
  int n_fail = 0;

  cmd_exec #(.FAST_SIM(1'b1), .MAX_FRWRD(10'h2A0)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
    .send_resp(send_resp), .cal_go(cal_go), .cal_done(cal_done), .heading_ok(heading_ok),
    .cntrIR(cntrIR), .dsrd_hdng(dsrd_hdng), .frwrd(frwrd), .moving(moving),
    .fanfare_go(fanfare_go)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one move command end to end, checking every output each cycle.
  // Ramp cycle j counts from the first RAMP_UP cycle; cntrIR rises at j = gap + i*per.
  task automatic run_move(input logic [15:0] c, input int hdly, input int gap, input int per,
                          input int nrise, input bit pend, input bit hdrop);
    int s, u, pk, k, rs, endc, j, f;
    logic [11:0] hexp;
    bit fan;
    s    = int'(c[3:0]);
    fan  = (c[15:12] == 4'h3);
    hexp = (c[11:4] == 8'h00) ? 12'h000 : 12'(int'(c[11:4]) * 16 + 15);
    u    = (s == 0) ? 0 : gap + (2 * s - 1) * per + 1;
    pk   = (u + 1) * INC;
    if (pk > MAXF) pk = MAXF;
    k    = (pk + 2 * INC - 1) / (2 * INC);
    rs   = hdly + 2;
    endc = rs + u + 1 + k;

    for (int t = 0; t <= endc; t++) begin
      j          = t - rs;
      cmd_rdy    = (t == 0) || (pend && t >= 1);
      cmd        = (pend && t >= 1) ? 16'h5123 : c;
      heading_ok = ((t >= hdly + 1) || (hdly == 0)) && !(hdrop && t > rs);
      cntrIR     = (j >= gap) && (((j - gap) % per) == 0) && (((j - gap) / per) < nrise);
      @(negedge clk);
      if (j <= 0)       f = 0;
      else if (j <= u)  f = (j * INC > MAXF) ? MAXF : j * INC;
      else              f = (pk - 2 * INC * (j - u - 1) < 0) ? 0 : pk - 2 * INC * (j - u - 1);
      chk("frwrd", 32'(frwrd), 32'(f));
      chk("clr_cmd_rdy", 32'(clr_cmd_rdy), 32'(t == 0));
      chk("send_resp", 32'(send_resp), 32'(t == endc));
      chk("fanfare_go", 32'(fanfare_go), 32'((t == endc) && fan));
      chk("cal_go", 32'(cal_go), 32'(0));
      if (t > 0) begin
        chk("moving", 32'(moving), 32'(1));
        chk("dsrd_hdng", 32'(dsrd_hdng), 32'(hexp));
      end
      next_cycle();
    end

    cntrIR     = 1'b0;
    heading_ok = 1'b0;
    @(negedge clk);
    chk("moving_after", 32'(moving), 32'(0));
    chk("frwrd_after", 32'(frwrd), 32'(0));
    chk("clr_after", 32'(clr_cmd_rdy), 32'(pend));
    chk("resp_after", 32'(send_resp), 32'(pend));
    chk("fanfare_after", 32'(fanfare_go), 32'(0));
    next_cycle();
    cmd_rdy = 1'b0;
    @(negedge clk);
    chk("resp_quiet", 32'(send_resp), 32'(0));
    chk("clr_quiet", 32'(clr_cmd_rdy), 32'(0));
    next_cycle();
  endtask

  initial begin
    logic [7:0] hdgs [4];
    logic [15:0] rc;
    int s;
    hdgs = '{HDG_N, HDG_W, HDG_S, HDG_E};
    rst = 1'b1; cmd = 16'h0; cmd_rdy = 1'b0; cal_done = 1'b0;
    heading_ok = 1'b0; cntrIR = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_frwrd", 32'(frwrd), 32'(0));
    chk("rst_moving", 32'(moving), 32'(0));
    chk("rst_hdng", 32'(dsrd_hdng), 32'(0));
    chk("rst_pulses", 32'({clr_cmd_rdy, send_resp, cal_go, fanfare_go}), 32'(0));
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Calibrate, cal_done twenty cycles after accept
    cmd = 16'h0000; cmd_rdy = 1'b1;
    @(negedge clk);
    chk("cal_clr", 32'(clr_cmd_rdy), 32'(1));
    chk("cal_go", 32'(cal_go), 32'(1));
    chk("cal_resp_early", 32'(send_resp), 32'(0));
    next_cycle();
    cmd_rdy = 1'b0;
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      chk("cal_wait_pulses", 32'({clr_cmd_rdy, send_resp, cal_go, fanfare_go}), 32'(0));
      next_cycle();
    end
    cal_done = 1'b1;
    @(negedge clk);
    chk("cal_resp", 32'({clr_cmd_rdy, send_resp, cal_go, fanfare_go}), 32'(4'b0100));
    next_cycle();
    cal_done = 1'b0;
    @(negedge clk);
    chk("cal_resp_once", 32'(send_resp), 32'(0));
    next_cycle();

    // West, two squares, saturating ramp
    run_move(16'h23F2, 5, 5, 6, 4, 1'b0, 1'b0);
    // East, one square, fanfare; heading_ok drops mid-ramp
    run_move(16'h3BF1, 1, 2, 3, 2, 1'b0, 1'b1);

    // Unsupported opcode acknowledged and answered together
    cmd = 16'h5123; cmd_rdy = 1'b1;
    @(negedge clk);
    chk("unsup_clr", 32'(clr_cmd_rdy), 32'(1));
    chk("unsup_resp", 32'(send_resp), 32'(1));
    chk("unsup_quiet", 32'({cal_go, fanfare_go, moving}), 32'(0));
    next_cycle();
    cmd_rdy = 1'b0;
    @(negedge clk);
    chk("unsup_resp_once", 32'(send_resp), 32'(0));
    next_cycle();

    // North, zero squares: minimum latency
    run_move(16'h2000, 0, 0, 2, 0, 1'b0, 1'b0);
    // Command held during a move is only acknowledged afterwards
    run_move(16'h27F1, 3, 1, 2, 2, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a ramp
    cmd = 16'h2001; cmd_rdy = 1'b1; heading_ok = 1'b1;
    next_cycle();
    cmd_rdy = 1'b0;
    repeat (5) next_cycle();
    @(negedge clk);
    chk("pre_rst_frwrd", 32'(frwrd), 32'(4 * INC));
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_frwrd", 32'(frwrd), 32'(0));
    chk("mid_rst_moving", 32'(moving), 32'(0));
    chk("mid_rst_hdng", 32'(dsrd_hdng), 32'(0));
    chk("mid_rst_pulses", 32'({clr_cmd_rdy, send_resp, cal_go, fanfare_go}), 32'(0));
    next_cycle();
    rst = 1'b0; heading_ok = 1'b0;
    next_cycle();
    run_move(16'h2001, 0, 1, 2, 2, 1'b0, 1'b0);

    // Randomized moves
    for (int n = 0; n < 10; n++) begin
      s  = $urandom_range(0, 4);
      rc = {($urandom_range(0, 1) != 0) ? 4'h3 : 4'h2, hdgs[$urandom_range(0, 3)], 4'(s)};
      run_move(rc, $urandom_range(0, 6), $urandom_range(0, 5), $urandom_range(2, 5),
               2 * s + $urandom_range(0, 2), 1'b0, $urandom_range(0, 1) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
